uart_frame_tx: RTL and testbench

- Upstream producer for the UART frame receiver/FIFO path.
- Pops 16-bit words from a FIFO and serialises each word as one UART frame: header byte, high byte, low byte, and an optional XOR checksum byte.
- Drives the existing uart core's transmit/tx_byte handshake and paces on is_transmitting.
- Used in loopback tests to feed uart2 so the receive framer rebuilds the same words.

---
 rtl/uart_frame_pkg.sv | 19 +
 rtl/uart_frame_tx.sv | 76 +++++++
 tb/tb_uart_frame_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: state encoding, header default, byte indices and byte selector shared by the uart frame tx/rx pair
package uart_frame_pkg;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POP       = 3'd1,
    S_LATCH     = 3'd2,
    S_SEND      = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_WAIT_DONE = 3'd5
  } state_t;
  localparam logic [7:0] HDR_DEFAULT = 8'h80;
  localparam logic [1:0] IDX_HDR = 2'd0;
  localparam logic [1:0] IDX_HI  = 2'd1;
  localparam logic [1:0] IDX_LO  = 2'd2;
  localparam logic [1:0] IDX_CHK = 2'd3;
  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [15:0] word, input logic [7:0] hdr);
    return idx == IDX_HDR ? hdr : idx == IDX_HI ? word[15:8] : idx == IDX_LO ? word[7:0] : word[15:8] ^ word[7:0];
  endfunction
endpackage

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: pops 16-bit fifo words and sends each as hdr,hi,lo[,hi^lo] through the uart transmit/is_transmitting handshake
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HDR       = HDR_DEFAULT,
  parameter bit         CHK_EN    = 1'b0,
  parameter int         START_TMO = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_rd_data,
  output logic        uart_transmit,
  output logic [7:0]  uart_tx_byte,
  input  logic        uart_is_transmitting,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        tmo_err
);
  localparam int TW = $clog2(START_TMO + 1);
  localparam logic [1:0] LAST = CHK_EN ? IDX_CHK : IDX_LO;
  state_t st, nxt;
  logic [1:0] idx;
  logic [15:0] word;
  logic [TW-1:0] tmo_cnt;
  logic done, tmo_hit;
  assign fifo_rd_en    = st == S_POP;
  assign uart_transmit = st == S_SEND;
  assign busy          = st != S_IDLE;
  always_comb begin
    nxt = st;
    done = 1'b0;
    tmo_hit = 1'b0;
    case (st)
      S_IDLE:      nxt = (en && !fifo_empty && !uart_is_transmitting) ? S_POP : S_IDLE;
      S_POP:       nxt = S_LATCH;
      S_LATCH:     nxt = S_SEND;
      S_SEND:      nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        nxt = uart_is_transmitting ? S_WAIT_DONE : S_WAIT_BUSY;
        tmo_hit = !uart_is_transmitting && (tmo_cnt + TW'(1) == TW'(START_TMO));
        done = tmo_hit;
      end
      S_WAIT_DONE: done = !uart_is_transmitting;
      default:     nxt = S_IDLE;
    endcase
    if (done) nxt = idx < LAST ? S_SEND : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      idx <= IDX_HDR;
      word <= '0;
      uart_tx_byte <= '0;
      tmo_cnt <= '0;
      frame_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      st <= nxt;
      if (st == S_LATCH) begin
        word <= fifo_rd_data;
        idx <= IDX_HDR;
        uart_tx_byte <= HDR;
      end
      if (st == S_SEND) tmo_cnt <= '0;
      else if (st == S_WAIT_BUSY && !uart_is_transmitting) tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_hit) tmo_err <= 1'b1;
      if (done && idx < LAST) begin
        idx <= idx + 2'd1;
        uart_tx_byte <= frame_byte(idx + 2'd1, word, HDR);
      end else if (done) frame_cnt <= frame_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: runs a CHK_EN=0 and a CHK_EN=1 instance against fifo/uart models and checks the byte stream against a frame model
module tb_uart_frame_tx;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [1:0] fifo_empty, fifo_rd_en, uart_transmit, is_tx, busy, tmo_err;
  logic [15:0] fifo_rd_data [2];
  logic [7:0] tx_byte [2];
  logic [15:0] frame_cnt [2];
  logic [15:0] mem [2][16];
  logic [7:0] log_b [2][256];
  logic [7:0] held [2];
  int log_c [2][256];
  int wr_p [2] = '{0, 0};
  int rd_p [2] = '{0, 0};
  int pops [2] = '{0, 0};
  int n_sent [2] = '{0, 0};
  int cnt [2] = '{0, 0};
  int gap [2] = '{0, 0};
  int gap_rise [2] = '{0, 0};
  int cyc = 0, viol = 0, busy_len = 10;
  bit dead = 1'b0, ext = 1'b0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : u
      uart_frame_tx #(.CHK_EN(g == 1)) dut (
        .clk(clk), .rst(rst), .en(en),
        .fifo_empty(fifo_empty[g]), .fifo_rd_en(fifo_rd_en[g]), .fifo_rd_data(fifo_rd_data[g]),
        .uart_transmit(uart_transmit[g]), .uart_tx_byte(tx_byte[g]), .uart_is_transmitting(is_tx[g]),
        .busy(busy[g]), .frame_cnt(frame_cnt[g]), .tmo_err(tmo_err[g])
      );
    end
  endgenerate
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fifo_empty[i] = rd_p[i] == wr_p[i];
      is_tx[i] = cnt[i] != 0 || ext;
    end
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (fifo_rd_en[i]) begin
        if (fifo_empty[i]) viol <= viol + 1;
        fifo_rd_data[i] <= mem[i][rd_p[i] % 16];
        rd_p[i] <= rd_p[i] + 1;
        pops[i] <= pops[i] + 1;
      end
      if (rst) cnt[i] <= 0;
      else if (uart_transmit[i]) begin
        log_b[i][n_sent[i] % 256] <= tx_byte[i];
        log_c[i][n_sent[i] % 256] <= cyc;
        n_sent[i] <= n_sent[i] + 1;
        held[i] <= tx_byte[i];
        cnt[i] <= dead ? 0 : busy_len;
      end else if (cnt[i] != 0) cnt[i] <= cnt[i] - 1;
      if (!rst && cnt[i] != 0 && tx_byte[i] !== held[i]) viol <= viol + 1;
      if (!busy[i]) gap[i] <= gap[i] + 1;
      else if (gap[i] != 0) begin
        gap_rise[i] <= gap[i];
        gap[i] <= 0;
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [15:0] a, input logic [15:0] b);
    mem[0][wr_p[0] % 16] = a;
    mem[1][wr_p[1] % 16] = b;
    wr_p[0]++;
    wr_p[1]++;
  endtask
  task automatic wait_frames(input string tag, input logic [15:0] t0, input logic [15:0] t1);
    for (int k = 0; k < 3000 && !(frame_cnt[0] == t0 && frame_cnt[1] == t1); k++) tick(1);
    check({tag, "_frames0"}, frame_cnt[0], t0);
    check({tag, "_frames1"}, frame_cnt[1], t1);
  endtask
  task automatic check_log(input string tag, input int i, input int base, input logic [15:0] w[$]);
    logic [7:0] e[$];
    foreach (w[k]) begin
      e.push_back(8'h80);
      e.push_back(w[k][15:8]);
      e.push_back(w[k][7:0]);
      if (i == 1) e.push_back(w[k][15:8] ^ w[k][7:0]);
    end
    check($sformatf("%s_nbytes%0d", tag, i), n_sent[i] - base, e.size());
    foreach (e[k]) check($sformatf("%s_byte%0d_%0d", tag, i, k), log_b[i][(base + k) % 256], e[k]);
  endtask
  initial begin
    logic [15:0] w0[$], w1[$];
    logic [15:0] r0, r1;
    int b0, b1, p0, p1;
    tick(3);
    check("rst_ctl", {fifo_rd_en, uart_transmit, busy, tmo_err}, 0);
    check("rst_byte", {tx_byte[0], tx_byte[1]}, 0);
    check("rst_cnt", {frame_cnt[0], frame_cnt[1]}, 0);
    rst = 1'b0;
    en = 1'b1;
    tick(2);
    check("idle_no_pop", {fifo_rd_en, busy}, 0);
    w0 = {16'h1234};
    w1 = {16'hA55A};
    b0 = n_sent[0]; b1 = n_sent[1]; p0 = pops[0]; p1 = pops[1];
    push(16'h1234, 16'hA55A);
    tick(1);
    check("pop_strobe", fifo_rd_en, 2'b11);
    tick(1);
    check("latch_quiet", {fifo_rd_en, uart_transmit}, 0);
    tick(1);
    check("first_tx", uart_transmit, 2'b11);
    check("first_hdr", {tx_byte[0], tx_byte[1]}, 16'h8080);
    wait_frames("t1", 16'd1, 16'd1);
    check("t1_busy_low", busy, 0);
    check("t1_pops", {pops[0] - p0, pops[1] - p1}, {32'd1, 32'd1});
    check_log("t1", 0, b0, w0);
    check_log("t1", 1, b1, w1);
    w0 = {16'h0001, 16'hFFFF};
    b0 = n_sent[0]; b1 = n_sent[1];
    push(16'h0001, 16'h0001);
    push(16'hFFFF, 16'hFFFF);
    wait_frames("t2", 16'd3, 16'd3);
    check_log("t2", 0, b0, w0);
    check_log("t2", 1, b1, w0);
    check("t2_gap", {gap_rise[0], gap_rise[1]}, {32'd1, 32'd1});
    w0 = {}; w1 = {};
    b0 = n_sent[0]; b1 = n_sent[1];
    busy_len = $urandom_range(1, 6);
    for (int k = 0; k < 5; k++) begin
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      w0.push_back(r0);
      w1.push_back(r1);
      push(r0, r1);
    end
    wait_frames("t3", 16'd8, 16'd8);
    check_log("t3", 0, b0, w0);
    check_log("t3", 1, b1, w1);
    busy_len = 10;
    ext = 1'b1;
    p0 = pops[0]; p1 = pops[1];
    b0 = n_sent[0]; b1 = n_sent[1];
    w0 = {16'h5AC3};
    push(16'h5AC3, 16'h5AC3);
    tick(20);
    check("ext_busy_block", {pops[0] - p0, pops[1] - p1, 30'd0, busy}, 0);
    ext = 1'b0;
    wait_frames("t4", 16'd9, 16'd9);
    check_log("t4", 0, b0, w0);
    check_log("t4", 1, b1, w0);
    check("pre_tmo", tmo_err, 0);
    dead = 1'b1;
    b0 = n_sent[0]; b1 = n_sent[1];
    w0 = {16'h1234};
    push(16'h1234, 16'h1234);
    wait_frames("t5", 16'd10, 16'd10);
    check("tmo_err", tmo_err, 2'b11);
    check_log("t5", 0, b0, w0);
    check_log("t5", 1, b1, w0);
    check("tmo_gap0", {log_c[0][(b0 + 1) % 256] - log_c[0][b0 % 256], log_c[0][(b0 + 2) % 256] - log_c[0][(b0 + 1) % 256]}, {32'd9, 32'd9});
    check("tmo_gap1", log_c[1][(b1 + 1) % 256] - log_c[1][b1 % 256], 9);
    dead = 1'b0;
    b0 = n_sent[0];
    push(16'h1234, 16'hA55A);
    for (int k = 0; k < 500 && n_sent[0] != b0 + 2; k++) tick(1);
    check("reach_hi", n_sent[0] - b0, 2);
    tick(3);
    rst = 1'b1;
    tick(1);
    check("abort_ctl", {fifo_rd_en, uart_transmit, busy, tmo_err}, 0);
    check("abort_byte", {tx_byte[0], tx_byte[1]}, 0);
    check("abort_cnt", {frame_cnt[0], frame_cnt[1]}, 0);
    rst = 1'b0;
    en = 1'b0;
    p0 = pops[0]; p1 = pops[1];
    push(16'hBEEF, 16'hBEEF);
    tick(30);
    check("en_block", {pops[0] - p0, pops[1] - p1, 30'd0, busy}, 0);
    b0 = n_sent[0]; b1 = n_sent[1];
    w0 = {16'hBEEF};
    en = 1'b1;
    wait_frames("t6", 16'd1, 16'd1);
    check_log("t6", 0, b0, w0);
    check_log("t6", 1, b1, w0);
    check("protocol_viol", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
